lcd_line_fetcher: RTL and testbench
===================================

// Module: lcd_line_fetcher
// PURPOSE
//  Avalon-MM read master that streams the 400x240 RGB565 frame buffer out of SDRAM
//  into a ping-pong line buffer and serves pixels to the LCD timing block.
//  Sits directly upstream of the LCD: it consumes the LCD's H/V scan addresses and
//  returns the 16-bit colour that the top level expands to 24 bits.
//  Each source line is shown on two LCD lines (2x vertical scaling); each pixel is
//  shown twice per line (2x horizontal scaling).
// PARAMETERS
//  H_SRC     400          source pixels per line
//  V_SRC     240          source lines per frame
//  FB_BASE   32'h0        byte address of pixel (0,0) in SDRAM
//  MAX_PEND  8            max outstanding Avalon reads (1..15)
// PORTS
//  clk              in   1   system/pixel clock (50 MHz); all logic on rising edge
//  rst              in   1   asynchronous, active-high reset
//  iFRAME_START     in   1   1-cycle strobe in vertical blanking, before LCD line 0
//  iLINE_START      in   1   1-cycle strobe at the start of each LCD line (haddr==0)
//  iHADDR           in   10  LCD column 0..799
//  iVADDR           in   9   LCD line 0..479
//  oRGB16           out  16  pixel for (iHADDR,iVADDR), RGB565
//  oUNDERRUN        out  1   sticky: a fetch was not finished in time
//  avm_address      out  32  byte address
//  avm_read         out  1   read request
//  avm_waitrequest  in   1   slave stall
//  avm_readdata     in   16  read data
//  avm_readdatavalid in  1   read data valid
// BEHAVIOUR
//  Reset: oRGB16=0, oUNDERRUN=0, avm_read=0, avm_address=FB_BASE, state=IDLE,
//   issue/receive counters=0, pending=0, fill bank=0.
//  Line buffer: 2 banks x H_SRC x 16 bit.
//  Display side:
//   - display bank = iVADDR[1] (source line = iVADDR>>1).
//   - read index = iHADDR>>1.
//   - oRGB16 registered; exactly 1 clk latency from iHADDR/iVADDR.
//  Fetch triggers:
//   - iFRAME_START: fetch source line 0 into bank 0; also clears oUNDERRUN.
//   - iLINE_START with iVADDR[0]==0 and (iVADDR>>1) < V_SRC-1: fetch source line
//     (iVADDR>>1)+1 into bank ~iVADDR[1].
//   - No fetch is issued on odd lines or on the last source line.
//  Fetch addressing:
//   - avm_address = FB_BASE + 2*(line*H_SRC + i), for i = 0..H_SRC-1, in order.
//   - Data is written to bank[fill][k] in arrival order, k = 0..H_SRC-1.
//  FSM states:
//   - IDLE: wait for a trigger. On a trigger, latch line and bank; go to ISSUE.
//   - ISSUE: drive avm_read=1 while issued<H_SRC and pending<MAX_PEND.
//       An address is accepted on a cycle with avm_read & !avm_waitrequest;
//       issued++ on acceptance. avm_read and avm_address are held stable while
//       avm_waitrequest=1. Go to DRAIN when issued==H_SRC.
//   - DRAIN: avm_read=0; wait until received==H_SRC, then return to IDLE.
//  pending count:
//   - incremented on acceptance, decremented on avm_readdatavalid.
//   - Acceptance and readdatavalid in the same cycle leave it unchanged.
//   - It never exceeds MAX_PEND.
//  Trigger while not IDLE:
//   - Set oUNDERRUN=1; the new trigger is ignored.
//   - The current fetch completes normally.
//   - iFRAME_START while busy is also ignored, except that it clears-then-sets oUNDERRUN
//     (net effect: oUNDERRUN=1).
//  Reset mid-fetch: abort immediately, return to the reset values above; counters are
//   cleared. Data arriving afterwards is not expected, because the slave is reset too.
//  Bounds: readdatavalid beyond H_SRC words in a fetch is ignored; never written to
//   the buffer.
//  Budget: one fetch has 1600 clk (2 LCD lines x 800) to complete; at a 50 MHz SDRAM
//   controller this is >3x margin.
// TESTING
//  1 Reset: assert rst mid-ISSUE -> avm_read=0 same cycle; oRGB16=0; oUNDERRUN=0.
//  2 Zero-wait slave (2-clk read latency, FB word i = i): iFRAME_START ->
//    - exactly 400 reads at byte addresses 0..798 step 2;
//    - then vaddr=0, haddr=6 -> oRGB16=16'd3 next clk.
//  3 Line start vaddr=0 -> fetch of line 1:
//    - first address 0x320; bank 1 filled;
//    - vaddr=2, haddr=0 -> oRGB16=16'd400.
//  4 waitrequest high for 5 clk every 3rd read -> address/read held stable while stalled;
//    - pending never > MAX_PEND=8;
//    - all 400 words correct.
//  5 Slave latency 10 clk, MAX_PEND=2 -> fetch exceeds 1600 clk;
//    - next trigger sets oUNDERRUN=1;
//    - iFRAME_START in IDLE clears oUNDERRUN.
//  6 vaddr=478 line start -> no Avalon reads issued (last source line 239).

Source files
------------

// File: rtl/lcd_line_fetcher_if.sv
// Avalon-MM read-only bus between the line fetcher and the SDRAM controller.
interface lcd_line_fetcher_if;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [15:0] avm_readdata;
    logic        avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );
endinterface

// File: rtl/lcd_line_fetcher.sv
// Streams RGB565 source lines from SDRAM into a ping-pong line buffer and
// serves 2x-scaled pixels to the LCD timing block.
module lcd_line_fetcher #(
    parameter int          H_SRC    = 400,
    parameter int          V_SRC    = 240,
    parameter logic [31:0] FB_BASE  = 32'h0,
    parameter int          MAX_PEND = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iFRAME_START,
    input  logic                iLINE_START,
    input  logic [9:0]          iHADDR,
    input  logic [8:0]          iVADDR,
    output logic [15:0]         oRGB16,
    output logic                oUNDERRUN,
    lcd_line_fetcher_if.master  avm
);

    localparam int CW = $clog2(H_SRC + 1);
    localparam int IW = CW + 1;
    localparam logic [CW-1:0] H_CNT  = CW'(H_SRC);
    localparam logic [7:0]    V_LAST = 8'(V_SRC - 1);
    localparam logic [3:0]    P_MAX  = 4'(MAX_PEND);
    localparam logic [31:0]   L_BYTES = 32'(2 * H_SRC);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] issued, received;
    logic [3:0]    pending;
    logic          fill;
    logic [31:0]   addr;
    logic [15:0]   mem [2*H_SRC];

    logic [7:0]    src_line;
    logic [7:0]    nxt_line;
    logic          line_trig, trig, accept, rdv_ok, rdv_dec;
    logic [9:0]    h_half;
    logic [IW-1:0] wr_idx, rd_idx;

    assign src_line  = 8'(iVADDR >> 1);
    assign line_trig = iLINE_START && !iVADDR[0] && (src_line < V_LAST);
    assign trig      = iFRAME_START || line_trig;
    assign nxt_line  = iFRAME_START ? 8'd0 : src_line + 8'd1;

    assign avm.avm_read    = (state == ISSUE) && (issued < H_CNT)
                             && (pending < P_MAX);
    assign avm.avm_address = addr;

    assign accept  = avm.avm_read && !avm.avm_waitrequest;
    // Words past the end of a line are dropped so the other bank stays intact.
    assign rdv_ok  = avm.avm_readdatavalid && (state != IDLE)
                     && (received < H_CNT);
    assign rdv_dec = avm.avm_readdatavalid && (pending != 4'd0);

    assign wr_idx = IW'(received) + (fill ? IW'(H_SRC) : IW'(0));
    assign h_half = iHADDR >> 1;
    assign rd_idx = IW'(h_half) + (iVADDR[1] ? IW'(H_SRC) : IW'(0));

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (trig) state_nx = ISSUE;
            ISSUE:   if (issued == H_CNT) state_nx = DRAIN;
            DRAIN:   if (received == H_CNT) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued   <= '0;
            received <= '0;
            fill     <= 1'b0;
            addr     <= FB_BASE;
        end else if (state == IDLE && trig) begin
            issued   <= '0;
            received <= '0;
            fill     <= iFRAME_START ? 1'b0 : ~iVADDR[1];
            addr     <= FB_BASE + 32'(nxt_line) * L_BYTES;
        end else begin
            if (accept) begin
                issued <= issued + 1'b1;
                addr   <= addr + 32'd2;
            end
            if (rdv_ok) received <= received + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            unique case ({accept, rdv_dec})
                2'b10:   pending <= pending + 1'b1;
                2'b01:   pending <= pending - 1'b1;
                default: pending <= pending;
            endcase
        end
    end

    // A busy trigger wins over the frame-start clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           oUNDERRUN <= 1'b0;
        else if (trig && state != IDLE)    oUNDERRUN <= 1'b1;
        else if (iFRAME_START)             oUNDERRUN <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rdv_ok) mem[wr_idx] <= avm.avm_readdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      oRGB16 <= '0;
        else if (h_half < 10'(H_SRC)) oRGB16 <= mem[rd_idx];
        else                          oRGB16 <= '0;
    end

endmodule

// File: tb/tb_lcd_line_fetcher.sv
// Directed/randomized bench for lcd_line_fetcher with an Avalon slave model
// whose frame buffer word i holds the value i.
module tb_lcd_line_fetcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        fs, ls;
    logic [9:0]  h;
    logic [8:0]  v;
    logic [15:0] rgb;
    logic        und;

    lcd_line_fetcher_if bus ();

    lcd_line_fetcher dut (
        .clk          (clk),
        .rst          (rst),
        .iFRAME_START (fs),
        .iLINE_START  (ls),
        .iHADDR       (h),
        .iVADDR       (v),
        .oRGB16       (rgb),
        .oUNDERRUN    (und),
        .avm          (bus)
    );

    always #10 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    int lat      = 2;
    bit stall_en = 1'b0;
    int stall    = 0;
    int cyc      = 0;
    int nresp    = 0;
    int nacc     = 0;
    bit prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    int          dueq [$];
    logic [15:0] datq [$];
    logic [31:0] alog [$];
    int bank_line [2];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_pix(int hh, int vv);
        return 32'((bank_line[(vv / 2) % 2] * 400 + hh / 2) % 65536);
    endfunction

    // Avalon slave: fixed latency, optional 5-cycle stall after every 3rd read
    always @(posedge clk or posedge rst) begin : slave
        logic acc;
        if (rst) begin
            dueq.delete();
            datq.delete();
            stall = 0;
            prev_stall = 1'b0;
            bus.avm_waitrequest   <= 1'b0;
            bus.avm_readdatavalid <= 1'b0;
            bus.avm_readdata      <= '0;
        end else begin
            cyc++;
            acc = bus.avm_read && !bus.avm_waitrequest;
            if (prev_stall) begin
                check("hold_read", 32'(bus.avm_read), 32'd1);
                check("hold_addr", bus.avm_address, prev_addr);
            end
            prev_stall = bus.avm_read && bus.avm_waitrequest;
            prev_addr  = bus.avm_address;
            if (acc) begin
                alog.push_back(bus.avm_address);
                dueq.push_back(cyc + lat);
                datq.push_back(16'(bus.avm_address >> 1));
                nacc++;
                check("pend_max", 32'(dueq.size() <= 8), 32'd1);
                if (stall_en && nacc % 3 == 0) stall = 5;
            end
            if (dueq.size() > 0 && dueq[0] <= cyc) begin
                bus.avm_readdatavalid <= 1'b1;
                bus.avm_readdata      <= datq.pop_front();
                void'(dueq.pop_front());
                nresp++;
            end else begin
                bus.avm_readdatavalid <= 1'b0;
            end
            if (stall > 0) begin
                bus.avm_waitrequest <= 1'b1;
                stall--;
            end else begin
                bus.avm_waitrequest <= 1'b0;
            end
        end
    end

    task automatic pulse_frame();
        @(negedge clk) fs = 1'b1;
        @(negedge clk) fs = 1'b0;
    endtask

    task automatic pulse_line(int vv);
        @(negedge clk);
        v  = 9'(vv);
        ls = 1'b1;
        @(negedge clk) ls = 1'b0;
    endtask

    task automatic wait_resp(int target);
        int t = 0;
        while (nresp < target && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("fetch_done", 32'(nresp >= target), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic pix(string tag, int hh, int vv);
        h = 10'(hh);
        v = 9'(vv);
        @(negedge clk);
        check(tag, 32'(rgb), model_pix(hh, vv));
    endtask

    initial begin
        int base, bad, hh, vv;
        rst = 1'b1; fs = 1'b0; ls = 1'b0; h = '0; v = '0;
        repeat (3) @(negedge clk);
        check("rst_rgb", 32'(rgb), 32'd0);
        check("rst_und", 32'(und), 32'd0);
        check("rst_read", 32'(bus.avm_read), 32'd0);
        check("rst_addr", bus.avm_address, 32'h0);
        rst = 1'b0;

        // Reset in the middle of issuing
        pulse_frame();
        repeat (5) @(negedge clk);
        check("t1_read_on", 32'(bus.avm_read), 32'd1);
        pulse_line(0);
        check("t1_und_set", 32'(und), 32'd1);
        rst = 1'b1;
        #1;
        check("t1_read_off", 32'(bus.avm_read), 32'd0);
        check("t1_rgb", 32'(rgb), 32'd0);
        check("t1_und", 32'(und), 32'd0);
        @(negedge clk) rst = 1'b0;

        // Frame start: source line 0 into bank 0
        alog.delete();
        base = nresp;
        pulse_frame();
        bank_line[0] = 0;
        wait_resp(base + 400);
        check("t2_nreads", 32'(alog.size()), 32'd400);
        bad = 0;
        foreach (alog[i]) if (alog[i] !== 32'(2 * i)) bad++;
        check("t2_addr_bad", 32'(bad), 32'd0);
        pix("t2_pix6", 6, 0);
        repeat (10) pix("t2_rand", $urandom_range(0, 799), $urandom_range(0, 1));

        // Line start at vaddr 0: source line 1 into bank 1
        alog.delete();
        base = nresp;
        pulse_line(0);
        bank_line[1] = 1;
        wait_resp(base + 400);
        check("t3_first", alog.size() > 0 ? alog[0] : 32'hx, 32'h320);
        pix("t3_pix0", 0, 2);
        repeat (10) pix("t3_rand", $urandom_range(0, 799), $urandom_range(0, 3));

        // Stalling slave: source line 2 into bank 0
        alog.delete();
        stall_en = 1'b1;
        base = nresp;
        pulse_line(2);
        bank_line[0] = 2;
        wait_resp(base + 400);
        stall_en = 1'b0;
        check("t4_nreads", 32'(alog.size()), 32'd400);
        bad = 0;
        foreach (alog[i]) if (alog[i] !== 32'(1600 + 2 * i)) bad++;
        check("t4_addr_bad", 32'(bad), 32'd0);
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            h = 10'(2 * i + 1);
            v = 9'd4;
            @(negedge clk);
            if (32'(rgb) !== model_pix(2 * i + 1, 4)) bad++;
        end
        check("t4_data_bad", 32'(bad), 32'd0);

        // Slow slave: triggers arriving while busy flag underrun
        lat = 10;
        alog.delete();
        base = nresp;
        pulse_line(4);
        bank_line[1] = 3;
        repeat (20) @(negedge clk);
        pulse_line(6);
        check("t5_und_busy", 32'(und), 32'd1);
        wait_resp(base + 400);
        check("t5_nreads", 32'(alog.size()), 32'd400);
        for (int i = 0; i < 8; i++) begin
            hh = $urandom_range(0, 799);
            vv = 2 + $urandom_range(0, 1);
            pix("t5_rand", hh, vv);
        end
        base = nresp;
        pulse_frame();
        check("t5_und_clr", 32'(und), 32'd0);
        bank_line[0] = 0;
        repeat (10) @(negedge clk);
        pulse_frame();
        check("t5_und_fs", 32'(und), 32'd1);
        wait_resp(base + 400);
        pix("t5_line0", 798, 1);

        // Last and odd lines issue nothing; 476 fetches line 239
        lat = 2;
        alog.delete();
        pulse_line(478);
        pulse_line(1);
        repeat (30) @(negedge clk);
        check("t6_no_reads", 32'(alog.size()), 32'd0);
        base = nresp;
        pulse_line(476);
        bank_line[1] = 239;
        wait_resp(base + 400);
        check("t6_first", alog.size() > 0 ? alog[0] : 32'hx, 32'd191200);
        pix("t6_pix", 799, 478);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
